// File: rtl/uart_responder_pkg.sv
// Shared types and constants for the UART responder.
//   ctrl_state_t : request-handling FSM states (IDLE, TX, RXWAIT)
//   rx_state_t   : receive deserializer FSM states
//   RORS_SEND / RORS_RECV : values of the request-type input
//   DEFAULT_CLKS_PER_BIT  : 100 MHz / 115200 baud
//   UART_FRAME_BITS       : start + 8 data + stop
package uart_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 868;
    localparam int   UART_FRAME_BITS      = 10;
    localparam logic RORS_SEND            = 1'b1;
    localparam logic RORS_RECV            = 1'b0;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_TX,
        CTRL_RXWAIT
    } ctrl_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_responder_if.sv
// Request/response handshake between the core controller and the UART responder.
//   uart_go    : 1-cycle request strobe (controller -> responder)
//   rors       : request type, 1 = send, 0 = receive
//   txdata     : byte to send
//   uart_done  : 1-cycle completion pulse (responder -> controller)
//   rxdata     : received byte, held until the next receive completes
//   rx_overrun : sticky flag, a received byte was dropped
interface uart_responder_if;

    logic       uart_go;
    logic       rors;
    logic [7:0] txdata;
    logic       uart_done;
    logic [7:0] rxdata;
    logic       rx_overrun;

    modport master (
        output uart_go, rors, txdata,
        input  uart_done, rxdata, rx_overrun
    );

    modport slave (
        input  uart_go, rors, txdata,
        output uart_done, rxdata, rx_overrun
    );

endinterface

// File: rtl/uart_responder_rx.sv
// 8N1 serial receiver, free-running and independent of the transmitter.
//   clk, rst : system clock, synchronous active-high reset
//   rxd      : asynchronous serial input
//   push     : 1-cycle strobe, rx_byte holds a correctly framed byte
//   rx_byte  : last assembled byte (stable while no frame is in its data phase)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       push,
    output logic [7:0] rx_byte
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state, state_nxt;
    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push_nxt;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign rx_byte  = shreg;

    // Two-flop synchronizer; held at the idle level in reset so no false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push_nxt  = 1'b0;
        case (state)
            RX_IDLE:  if (!sync2) state_nxt = RX_START;
            // Mid-start-bit re-check rejects short glitches.
            RX_START: if (cnt_zero) state_nxt = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_zero && bit_idx == 3'd7) state_nxt = RX_STOP;
            // Leave right after the stop sample so a following start bit is caught.
            RX_STOP: begin
                if (cnt_zero) begin
                    state_nxt = RX_IDLE;
                    push_nxt  = sync2;
                end
            end
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) push <= 1'b0;
        else     push <= push_nxt;
    end

    // Sample counter and shift register; reloaded from IDLE, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == RX_IDLE) begin
            cnt     <= HALF_M1;
            bit_idx <= 3'd0;
        end else if (cnt_zero) begin
            cnt <= FULL_M1;
            if (state == RX_DATA) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_responder.sv
// UART responder for the core's SENDB/RECVB handshake: transmits one 8N1 byte
// or returns one byte from the RX FIFO, then pulses uart_done.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of uart_responder_if (go/rors/txdata in, done/rxdata/overrun out)
//   uart_txd : serial output, idles high
//   uart_rxd : asynchronous serial input
module uart_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_responder_if.slave bus,
    output logic            uart_txd,
    input  logic            uart_rxd
);

    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_M1    = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    FRAME_LAST = 4'(UART_FRAME_BITS - 1);

    ctrl_state_t   state, state_nxt;
    logic          pop, tx_start, done_nxt;
    logic          done_r, overrun_r;
    logic [7:0]    rxdata_r;

    logic          rx_push;
    logic [7:0]    rx_byte;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, wr_en;

    logic [8:0]    tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_last;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rxd     (uart_rxd),
        .push    (rx_push),
        .rx_byte (rx_byte)
    );

    assign bus.uart_done  = done_r;
    assign bus.rxdata     = rxdata_r;
    assign bus.rx_overrun = overrun_r;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en   = rx_push && (!full || pop);
    assign tx_last = (tx_cnt == '0) && (tx_bit == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= CTRL_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_start  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            CTRL_IDLE: begin
                if (bus.uart_go) begin
                    if (bus.rors == RORS_SEND) begin
                        tx_start  = 1'b1;
                        state_nxt = CTRL_TX;
                    end else if (!empty) begin
                        pop      = 1'b1;
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = CTRL_RXWAIT;
                    end
                end
            end
            CTRL_TX: begin
                if (tx_last) begin
                    done_nxt  = 1'b1;
                    state_nxt = CTRL_IDLE;
                end
            end
            CTRL_RXWAIT: begin
                if (!empty) begin
                    pop       = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = CTRL_IDLE;
                end
            end
            default: state_nxt = CTRL_IDLE;
        endcase
    end

    // Registered outputs; a reset mid-frame returns the line to idle at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r   <= 1'b0;
            rxdata_r <= 8'h00;
            uart_txd <= 1'b1;
        end else begin
            done_r <= done_nxt;
            if (pop) rxdata_r <= mem[rd_ptr[AW-1:0]];
            if (tx_start) begin
                uart_txd <= 1'b0;
            end else if (state == CTRL_TX && tx_cnt == '0) begin
                uart_txd <= tx_last ? 1'b1 : tx_sh[0];
            end
        end
    end

    // TX shifter holds the data bits then the stop bit; reloaded on every start.
    always_ff @(posedge clk) begin
        if (tx_start) begin
            tx_sh  <= {1'b1, bus.txdata};
            tx_cnt <= FULL_M1;
            tx_bit <= 4'd0;
        end else if (state == CTRL_TX) begin
            if (tx_cnt == '0) begin
                tx_sh  <= {1'b0, tx_sh[8:1]};
                tx_cnt <= FULL_M1;
                tx_bit <= tx_bit + 4'd1;
            end else begin
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (rx_push && full && !pop) overrun_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_byte;
    end

endmodule
